// File: rtl/sensor_irq_aggregator.sv
// Multi-channel sensor interrupt collector: sync, debounce, polarity, level/edge pending,
// overrun capture and mask, behind a zero-wait Avalon-MM slave with one combined irq.
module sensor_irq_aggregator #(
  parameter int unsigned           NUM_CH     = 4,
  parameter int unsigned           DEBOUNCE_W = 8,
  parameter logic [NUM_CH-1:0]     POL_RESET  = '0,
  parameter logic [NUM_CH-1:0]     MODE_RESET = '0,
  parameter logic [DEBOUNCE_W-1:0] DEB_RESET  = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [NUM_CH-1:0] irq_in,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest,
  output logic              irq
);

  logic [NUM_CH-1:0]     sync1_q, sync2_q;
  logic [NUM_CH-1:0]     deb_q, deb_d;
  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     ovr_q, ovr_d;
  logic [NUM_CH-1:0]     mask_q, pol_q, mode_q;
  logic [DEBOUNCE_W-1:0] deb_cfg_q;
  logic [DEBOUNCE_W-1:0] cnt_q [NUM_CH];
  logic [DEBOUNCE_W-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] asserted, rise;
  logic [NUM_CH-1:0] w1c_pend, w1c_ovr;
  logic [31:0]       be_mask;
  logic [31:0]       mask_wr, pol_wr, mode_wr, deb_wr, clr_wr;
  logic [31:0]       rd_mux;
  logic              wr_mask, wr_pol, wr_mode, wr_deb, wr_pend, wr_ovr;
  logic              rd_en;
  logic              unused_bits;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [31:0] m);
    return (old & ~m) | (wd & m);
  endfunction

  assign be_mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                    {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};

  assign wr_pend = avs_write && (avs_address == 3'd1);
  assign wr_mask = avs_write && (avs_address == 3'd2);
  assign wr_pol  = avs_write && (avs_address == 3'd3);
  assign wr_mode = avs_write && (avs_address == 3'd4);
  assign wr_deb  = avs_write && (avs_address == 3'd5);
  assign wr_ovr  = avs_write && (avs_address == 3'd6);
  // A simultaneous write takes priority and suppresses the read.
  assign rd_en   = avs_read && !avs_write;

  assign mask_wr = merge(32'(mask_q), avs_writedata, be_mask);
  assign pol_wr  = merge(32'(pol_q), avs_writedata, be_mask);
  assign mode_wr = merge(32'(mode_q), avs_writedata, be_mask);
  assign deb_wr  = merge(32'(deb_cfg_q), avs_writedata, be_mask);
  assign clr_wr  = avs_writedata & be_mask;

  assign w1c_pend = wr_pend ? clr_wr[NUM_CH-1:0] : '0;
  assign w1c_ovr  = wr_ovr ? clr_wr[NUM_CH-1:0] : '0;

  assign unused_bits = ^{mask_wr, pol_wr, mode_wr, deb_wr, clr_wr};

  assign asserted = sync2_q ^ pol_q;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cnt_d[i] = '0;
      if (asserted[i] != deb_q[i]) begin
        if (cnt_q[i] == deb_cfg_q) begin
          deb_d[i] = asserted[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Pending follows the debounce update on the same edge, giving 3 + DEBOUNCE latency.
  assign rise   = deb_d & ~deb_q;
  assign pend_d = (mode_q & ((pend_q & ~w1c_pend) | rise)) | (~mode_q & deb_d);
  assign ovr_d  = (ovr_q & ~w1c_ovr) | (mode_q & rise & pend_q);

  always_comb begin
    rd_mux = '0;
    case (avs_address)
      3'd0:    rd_mux = 32'(deb_q);
      3'd1:    rd_mux = 32'(pend_q);
      3'd2:    rd_mux = 32'(mask_q);
      3'd3:    rd_mux = 32'(pol_q);
      3'd4:    rd_mux = 32'(mode_q);
      3'd5:    rd_mux = 32'(deb_cfg_q);
      3'd6:    rd_mux = 32'(ovr_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      pend_q    <= '0;
      ovr_q     <= '0;
      mask_q    <= '0;
      pol_q     <= POL_RESET;
      mode_q    <= MODE_RESET;
      deb_cfg_q <= DEB_RESET;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (wr_mask) mask_q    <= mask_wr[NUM_CH-1:0];
      if (wr_pol)  pol_q     <= pol_wr[NUM_CH-1:0];
      if (wr_mode) mode_q    <= mode_wr[NUM_CH-1:0];
      if (wr_deb)  deb_cfg_q <= deb_wr[DEBOUNCE_W-1:0];
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= rd_en;
      if (rd_en) avs_readdata <= rd_mux;
    end
  end

  assign avs_waitrequest = 1'b0;
  assign irq             = |(pend_q & mask_q);

endmodule

// File: tb/tb_sensor_irq_aggregator.sv
// Directed bench: register reads are checked by a scoreboard monitor, irq timing is checked
// directly by the stimulus process.
module tb_sensor_irq_aggregator;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [3:0]  irq_in;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int mon_checks = 0;
  int mon_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk_clk = ~clk_clk;

  sensor_irq_aggregator #(
    .NUM_CH     (4),
    .DEBOUNCE_W (8),
    .POL_RESET  (4'b0100),
    .MODE_RESET (4'b0000),
    .DEB_RESET  (8'd0)
  ) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .irq_in            (irq_in),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .irq               (irq)
  );

  // Scoreboard monitor: one expectation per readdatavalid pulse.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk_clk);
      if (!reset_reset && avs_readdatavalid) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_errors++;
          $display("FAIL unexpected_valid got readdata=%h with no read pending", avs_readdata);
        end else begin
          e = exp_q.pop_front();
          if (avs_readdata !== e) begin
            mon_errors++;
            $display("FAIL readdata got %h expected %h", avs_readdata, e);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    avs_write      = 1'b1;
    step(1);
    avs_write      = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e);
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(e);
    step(1);
    avs_read    = 1'b0;
  endtask

  initial begin
    reset_reset    = 1'b1;
    irq_in         = 4'b0100;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = 4'hF;
    step(2);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_rdv", 32'(avs_readdatavalid), 32'd0);
    check("reset_readdata", avs_readdata, 32'd0);
    check("waitrequest", 32'(avs_waitrequest), 32'd0);
    reset_reset = 1'b0;
    step(5);
    rd(3'd0, 32'h0);
    rd(3'd1, 32'h0);
    rd(3'd3, 32'h4);
    check("post_reset_irq", 32'(irq), 32'd0);

    // Return all pins to idle-low, active-high.
    irq_in = 4'b0000;
    wr(3'd3, 32'h0, 4'hF);
    step(6);
    rd(3'd1, 32'h0);

    // Level mode, no debounce, channel 0.
    wr(3'd2, 32'h1, 4'hF);
    irq_in[0] = 1'b1;
    step(2);
    check("lvl_rise_early", 32'(irq), 32'd0);
    step(1);
    check("lvl_rise_3clk", 32'(irq), 32'd1);
    wr(3'd1, 32'h1, 4'hF);
    rd(3'd1, 32'h1);
    check("lvl_w1c_held_irq", 32'(irq), 32'd1);
    irq_in[0] = 1'b0;
    step(2);
    check("lvl_fall_early", 32'(irq), 32'd1);
    step(1);
    check("lvl_fall_3clk", 32'(irq), 32'd0);
    rd(3'd1, 32'h0);

    // Edge mode on ch1/ch2, debounce 5 on ch1.
    wr(3'd5, 32'h5, 4'hF);
    wr(3'd4, 32'h6, 4'hF);
    wr(3'd2, 32'h2, 4'hF);
    irq_in[1] = 1'b1;
    step(4);
    irq_in[1] = 1'b0;
    step(12);
    rd(3'd1, 32'h0);
    rd(3'd0, 32'h0);
    irq_in[1] = 1'b1;
    step(7);
    check("deb5_early", 32'(irq), 32'd0);
    step(1);
    check("deb5_8clk", 32'(irq), 32'd1);
    step(4);
    irq_in[1] = 1'b0;
    step(12);
    check("edge_fall_kept", 32'(irq), 32'd1);
    rd(3'd1, 32'h2);
    rd(3'd0, 32'h0);
    wr(3'd1, 32'h2, 4'hF);
    rd(3'd1, 32'h0);
    check("edge_w1c_irq", 32'(irq), 32'd0);

    // Overrun on ch2, debounce back to 0.
    wr(3'd5, 32'h0, 4'hF);
    irq_in[2] = 1'b1;
    step(4);
    irq_in[2] = 1'b0;
    step(4);
    irq_in[2] = 1'b1;
    step(4);
    irq_in[2] = 1'b0;
    step(6);
    rd(3'd1, 32'h4);
    rd(3'd6, 32'h4);
    wr(3'd6, 32'h4, 4'hF);
    rd(3'd6, 32'h0);
    rd(3'd1, 32'h4);
    // W1C lands on the same edge as a new debounced rise: set wins.
    irq_in[2] = 1'b1;
    step(2);
    wr(3'd1, 32'h4, 4'hF);
    rd(3'd1, 32'h4);
    rd(3'd6, 32'h4);
    irq_in[2] = 1'b0;
    step(6);
    wr(3'd1, 32'h4, 4'hF);
    rd(3'd1, 32'h0);

    // Active-low ch3 in level mode, masked then unmasked.
    wr(3'd3, 32'h8, 4'hF);
    step(6);
    rd(3'd1, 32'h8);
    check("pol_masked_irq", 32'(irq), 32'd0);
    wr(3'd2, 32'h8, 4'hF);
    check("pol_unmask_irq", 32'(irq), 32'd1);

    // Back-to-back reads.
    avs_read = 1'b1;
    avs_address = 3'd2;
    exp_q.push_back(32'h8);
    step(1);
    avs_address = 3'd3;
    exp_q.push_back(32'h8);
    step(1);
    avs_address = 3'd7;
    exp_q.push_back(32'h0);
    step(1);
    avs_read = 1'b0;

    // Byteenable and upper-bit masking.
    wr(3'd2, 32'hFF, 4'h0);
    rd(3'd2, 32'h8);
    wr(3'd2, 32'hFF, 4'h1);
    rd(3'd2, 32'hF);
    wr(3'd5, 32'h0000_3C00, 4'h2);
    rd(3'd5, 32'h0);
    wr(3'd5, 32'h0000_0033, 4'h1);
    rd(3'd5, 32'h33);

    // Read and write together: write only, no valid.
    avs_address   = 3'd2;
    avs_writedata = 32'h8;
    avs_byteenable = 4'hF;
    avs_read      = 1'b1;
    avs_write     = 1'b1;
    step(1);
    avs_read  = 1'b0;
    avs_write = 1'b0;
    step(2);
    rd(3'd2, 32'h8);

    // Reset while a read response is in flight.
    avs_address = 3'd2;
    avs_read    = 1'b1;
    @(posedge clk_clk);
    #1;
    reset_reset = 1'b1;
    avs_read    = 1'b0;
    step(1);
    check("reset_drops_rdv", 32'(avs_readdatavalid), 32'd0);
    check("reset_irq_again", 32'(irq), 32'd0);
    reset_reset = 1'b0;
    step(1);
    rd(3'd3, 32'h4);
    rd(3'd2, 32'h0);

    step(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks + mon_checks, errors + mon_errors);
    $finish;
  end

endmodule

// File: doc/sensor_irq_aggregator.md
Name: sensor_irq_aggregator

Overview:
- Parametrised N-channel interrupt/data-ready collector for the sensor subsystem; replaces one fixed single-bit input PIO per sensor (light, IMU, RH/temp DRDY_n).
- Per channel: input synchroniser, programmable debounce, per-channel polarity, level/edge mode, sticky pending, mask and overrun capture.
- Exposes an Avalon-MM slave to the Nios/HPS bridge fabric and drives one combined interrupt line.

Parameters:
- NUM_CH, 4, number of input channels (1..32)
- DEBOUNCE_W, 8, debounce counter/register width (1..16)
- POL_RESET, 0, reset value of POLARITY register (NUM_CH bits)
- MODE_RESET, 0, reset value of MODE register (NUM_CH bits)
- DEB_RESET, 0, reset value of DEBOUNCE register

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- irq_in  in  NUM_CH  raw asynchronous sensor interrupt pins
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_byteenable  in  4  byte lanes
- avs_readdata  out  32  read data
- avs_readdatavalid  out  1  read data qualifier
- avs_waitrequest  out  1  constant 0
- irq  out  1  OR of (PENDING & MASK)

Behaviour:
- Reset, asynchronous, active-high; all flops cleared except:
  - POLARITY = POL_RESET, MODE = MODE_RESET, DEBOUNCE = DEB_RESET.
  - Synchronisers, debounced state, counters, PENDING, OVERRUN, MASK = 0.
  - avs_readdata = 0, avs_readdatavalid = 0, irq = 0.
  - Reset mid-transaction drops any pending readdatavalid.
- Register map (word addresses):
  - 0 RAW (RO): debounced asserted state.
  - 1 PENDING (W1C).
  - 2 MASK (RW).
  - 3 POLARITY (RW): 1 = active-low.
  - 4 MODE (RW): 0 = level, 1 = edge.
  - 5 DEBOUNCE (RW): low DEBOUNCE_W bits.
  - 6 OVERRUN (W1C).
  - 7 reads 0.
- Bits at and above NUM_CH read 0 and ignore writes. Byteenable is honoured per lane on all writable registers.
- Input path, per channel:
  - Two-flop synchroniser on irq_in.
  - asserted = sync2 XOR POLARITY.
  - Debounce counter increments each cycle asserted != deb; it clears when they match.
  - deb takes asserted on the edge where counter == DEBOUNCE, and the counter clears on that edge.
  - DEBOUNCE = 0 gives a deb update on the first mismatching cycle.
- Latency: pin change to PENDING/irq = 3 + DEBOUNCE clocks. irq is combinational from the PENDING and MASK registers.
- Level mode: PENDING[i] = deb[i], registered. W1C has no effect while deb[i] = 1.
- Edge mode: PENDING[i] set on the cycle after deb[i] rises 0->1; falling edges are ignored.
  - W1C clears it.
  - Set and W1C in the same cycle: set wins.
  - Rising edge while PENDING[i] already 1: OVERRUN[i] set. Same set-wins rule for OVERRUN vs its W1C.
- Changing MODE or POLARITY at runtime is not filtered. A resulting deb transition behaves as a real event; software clears PENDING afterwards.
- MASK affects irq only. PENDING still latches while masked.
- Read: avs_readdatavalid pulses one cycle after avs_read. avs_readdata holds the register value sampled at the read edge (pre-update) and holds until the next read.
- avs_read and avs_write in the same cycle: write only, no readdatavalid.
- Back-to-back reads every cycle are supported, with one valid per read.

Test Plan:
- Reset with POL_RESET=4'b0100, irq_in=4'b0100 -> RAW=0, PENDING=0, irq=0, POLARITY reads 0x4, readdatavalid=0.
- DEBOUNCE=0, MODE=0, MASK=0x1; raise irq_in[0] -> PENDING[0]=1 and irq=1 exactly 3 clocks later. W1C 0x1 while held -> PENDING stays 1. Drop pin -> PENDING=0 after 3 clocks, irq=0.
- DEBOUNCE=5, MODE=1: 4-cycle glitch on irq_in[1] -> no change. 12-cycle pulse -> PENDING[1]=1 at 8 clocks after rise; falling edge does not clear it.
- Edge mode ch2: two rising edges without clear -> PENDING[2]=1, OVERRUN[2]=1. W1C OVERRUN 0x4 -> 0. W1C PENDING coinciding with a new deb rise -> PENDING[2] stays 1.
- POLARITY[3]=1, MASK[3]=0: pin driven low -> PENDING[3]=1, irq=0. Write MASK=0x8 -> irq=1 next cycle.
- Consecutive reads of addresses 2,3,7 on three cycles -> three readdatavalid pulses one cycle later with MASK, POLARITY, 0. Write MASK 0xFF with byteenable=0x0 -> MASK unchanged.
